// File: rtl/pipe_rr_arbiter_if.sv
// Handshake bundle between N producers, the shared output stage and its consumer.
// PIPE_ARB_SRCID_EN adds the osrc source-index signal.
interface pipe_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_rdy;
  logic           rdy;
  logic           ovalid;
  logic [W-1:0]   dout;
  logic [N-1:0]   grant;
  logic           busy;
`ifdef PIPE_ARB_SRCID_EN
  logic [IW-1:0]  osrc;

  modport master (
    output req_valid, req_data, rdy,
    input  req_rdy, ovalid, dout, grant, busy, osrc
  );
  modport slave (
    input  req_valid, req_data, rdy,
    output req_rdy, ovalid, dout, grant, busy, osrc
  );
`else
  modport master (
    output req_valid, req_data, rdy,
    input  req_rdy, ovalid, dout, grant, busy
  );
  modport slave (
    input  req_valid, req_data, rdy,
    output req_rdy, ovalid, dout, grant, busy
  );
`endif
endinterface

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter that owns a registered output stage, with bounded per-owner bursts.
// Optional PIPE_ARB_SRCID_EN registers the source index of the held beat on osrc.
module pipe_rr_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  pipe_rr_arbiter_if.slave bus
);
  localparam int         IW         = $clog2(N);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t        st_reg, st_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          ovalid_reg, ovalid_next;
  logic [W-1:0]  dout_reg, dout_next;
`ifdef PIPE_ARB_SRCID_EN
  logic [IW-1:0] osrc_reg, osrc_next;
`endif

  logic [W-1:0]  data_arr [N];
  logic [IW-1:0] rot_idx [N];
  logic          load_en;
  logic          found;
  logic [IW-1:0] sel;
  logic [IW-1:0] ptr_inc;
  logic [3:0]    cnt_inc;
  logic [N-1:0]  req_rdy_c;

  // Unpack data lanes, precompute the scan order starting at ptr, and decode grant.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [IW:0] rot_sum;
      assign data_arr[gi]  = bus.req_data[gi*W +: W];
      assign rot_sum       = {1'b0, ptr_reg} + (IW+1)'(gi);
      assign rot_idx[gi]   = (rot_sum >= (IW+1)'(N)) ? IW'(rot_sum - (IW+1)'(N))
                                                     : rot_sum[IW-1:0];
      assign bus.grant[gi] = (st_reg == OWN) && (owner_reg == IW'(gi));
    end
  endgenerate

  assign load_en = ~ovalid_reg | bus.rdy;

  // A locked owner that is still valid beats any round-robin candidate.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req_valid[rot_idx[k]]) begin
        found = 1'b1;
        sel   = rot_idx[k];
      end
    end
    if (st_reg == OWN && bus.req_valid[owner_reg]) begin
      found = 1'b1;
      sel   = owner_reg;
    end
  end

  assign ptr_inc = (sel == IW'(N-1)) ? '0 : sel + IW'(1);
  assign cnt_inc = (st_reg == OWN && sel == owner_reg) ? cnt_reg + 4'd1 : 4'd1;

  always_comb begin
    req_rdy_c   = '0;
    st_next     = st_reg;
    owner_next  = owner_reg;
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    ovalid_next = ovalid_reg;
    dout_next   = dout_reg;
`ifdef PIPE_ARB_SRCID_EN
    osrc_next   = osrc_reg;
`endif
    if (load_en) begin
      if (found) begin
        req_rdy_c[sel] = ~rst;
        dout_next      = data_arr[sel];
        ovalid_next    = 1'b1;
        ptr_next       = ptr_inc;
        owner_next     = sel;
        cnt_next       = cnt_inc;
        st_next        = (cnt_inc == BURST_LAST) ? IDLE : OWN;
`ifdef PIPE_ARB_SRCID_EN
        osrc_next      = sel;
`endif
      end else begin
        // ptr is left alone so a yielding owner stays lowest priority.
        ovalid_next = 1'b0;
        st_next     = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg     <= IDLE;
      owner_reg  <= '0;
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      ovalid_reg <= 1'b0;
      dout_reg   <= '0;
`ifdef PIPE_ARB_SRCID_EN
      osrc_reg   <= '0;
`endif
    end else begin
      st_reg     <= st_next;
      owner_reg  <= owner_next;
      ptr_reg    <= ptr_next;
      cnt_reg    <= cnt_next;
      ovalid_reg <= ovalid_next;
      dout_reg   <= dout_next;
`ifdef PIPE_ARB_SRCID_EN
      osrc_reg   <= osrc_next;
`endif
    end
  end

  assign bus.req_rdy = req_rdy_c;
  assign bus.ovalid  = ovalid_reg;
  assign bus.dout    = dout_reg;
  assign bus.busy    = (st_reg == OWN);
`ifdef PIPE_ARB_SRCID_EN
  assign bus.osrc    = osrc_reg;
`endif

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Table-driven bench with a data scoreboard for pipe_rr_arbiter (burst 4) plus a
// per-beat round-robin instance (burst 1); osrc is checked when PIPE_ARB_SRCID_EN is defined.
module tb_pipe_rr_arbiter;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [31:0] DSTD = 32'h44332211;

  pipe_rr_arbiter_if #(.N(4), .W(8)) if0 ();
  pipe_rr_arbiter_if #(.N(4), .W(8)) if1 ();

  pipe_rr_arbiter #(.N(4), .W(8), .MAX_BURST(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
  pipe_rr_arbiter #(.N(4), .W(8), .MAX_BURST(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         r;
    logic [3:0] v;
    logic [3:0] erdy;
    logic [3:0] egnt;
    bit         ebusy;
    bit         eov;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sbq[$];

  task automatic add(input bit r, input logic [3:0] v, input logic [3:0] erdy,
                     input logic [3:0] egnt, input bit ebusy, input bit eov);
    tbl.push_back('{r, v, erdy, egnt, ebusy, eov});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input logic [3:0] v, input logic [31:0] d, input bit y);
    @(negedge clk);
    rst           = r;
    if0.req_valid = v;
    if0.req_data  = d;
    if0.rdy       = y;
    #1;
  endtask

  // Pop on a downstream transfer, then push the beat expected to be accepted this cycle.
  task automatic sb_step(input logic [3:0] acc, input logic [31:0] d);
    logic [7:0] e;
    if (rst) begin
      sbq.delete();
    end else begin
      if (if0.ovalid && if0.rdy) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%0h required=no_beat", if0.dout);
        end else begin
          e = sbq.pop_front();
          chk("sb_dout", 32'(if0.dout), 32'(e));
        end
      end
      for (int i = 0; i < 4; i++)
        if (acc[i]) sbq.push_back(d[i*8 +: 8]);
    end
  endtask

  initial begin
    rst           = 1'b1;
    if0.req_valid = '0;
    if0.req_data  = DSTD;
    if0.rdy       = 1'b1;
    if1.req_valid = '0;
    if1.req_data  = DSTD;
    if1.rdy       = 1'b1;

    // Full contention: 0x4, 1x4, 2x4, 3x4, then 0 again
    for (int s = 0; s < 4; s++) begin
      add(0, 4'b1111, 4'(1 << s), 4'b0000, 0, (s != 0));
      for (int k = 0; k < 3; k++) add(0, 4'b1111, 4'(1 << s), 4'(1 << s), 1, 1);
    end
    add(0, 4'b1111, 4'b0001, 4'b0000, 0, 1);
    // Lone requester 2: burst of 4, busy drops one cycle, beats never stop
    add(0, 4'b0100, 4'b0100, 4'b0001, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 4'b0100, 4'b0100, 4'b0100, 1, 1);
    add(0, 4'b0100, 4'b0100, 4'b0000, 0, 1);
    for (int k = 0; k < 2; k++) add(0, 4'b0100, 4'b0100, 4'b0100, 1, 1);
    // Owner 1 at cnt=2 drops valid; 3 takes over with no bubble
    add(0, 4'b0010, 4'b0010, 4'b0100, 1, 1);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 1);
    add(0, 4'b1001, 4'b1000, 4'b0010, 1, 1);
    add(0, 4'b1001, 4'b1000, 4'b1000, 1, 1);
    // Reset mid-burst, then restart from requester 0
    add(1, 4'b1001, 4'b0000, 4'b1000, 1, 1);
    add(0, 4'b1001, 4'b0001, 4'b0000, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0001, 1, 1);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    drive(1, 4'b1111, DSTD, 1);
    drive(1, 4'b1111, DSTD, 1);
    chk("rst_ovalid",  32'(if0.ovalid),  32'(0));
    chk("rst_dout",    32'(if0.dout),    32'(0));
    chk("rst_grant",   32'(if0.grant),   32'(0));
    chk("rst_busy",    32'(if0.busy),    32'(0));
    chk("rst_req_rdy", 32'(if0.req_rdy), 32'(0));

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].r, tbl[r].v, DSTD, 1);
      $display("row %0d rst=%0b valid=%b req_rdy=%b grant=%b busy=%0b ovalid=%0b dout=%h",
               r, tbl[r].r, tbl[r].v, if0.req_rdy, if0.grant, if0.busy, if0.ovalid, if0.dout);
      chk($sformatf("row%0d_req_rdy", r), 32'(if0.req_rdy), 32'(tbl[r].erdy));
      chk($sformatf("row%0d_grant", r),   32'(if0.grant),   32'(tbl[r].egnt));
      chk($sformatf("row%0d_busy", r),    32'(if0.busy),    32'(tbl[r].ebusy));
      chk($sformatf("row%0d_ovalid", r),  32'(if0.ovalid),  32'(tbl[r].eov));
      sb_step(tbl[r].erdy & tbl[r].v, DSTD);
    end

    // Stall: 0xA5 held 5 cycles while upstream data changes underneath
    drive(0, 4'b0010, 32'h4433A511, 1);
    chk("stall_load_req_rdy", 32'(if0.req_rdy), 32'(4'b0010));
    sb_step(4'b0010, 32'h4433A511);
    for (int k = 0; k < 5; k++) begin
      drive(0, 4'b1111, (k < 2) ? 32'h4433A511 : 32'h44335A11, 0);
      $display("stall %0d dout=%h ovalid=%0b req_rdy=%b", k, if0.dout, if0.ovalid, if0.req_rdy);
      chk($sformatf("stall%0d_dout", k),    32'(if0.dout),    32'h0000_00A5);
      chk($sformatf("stall%0d_ovalid", k),  32'(if0.ovalid),  32'(1));
      chk($sformatf("stall%0d_req_rdy", k), 32'(if0.req_rdy), 32'(0));
      chk($sformatf("stall%0d_grant", k),   32'(if0.grant),   32'(4'b0010));
      sb_step(4'b0000, 32'h44335A11);
    end
    drive(0, 4'b1111, 32'h44335A11, 1);
    chk("unstall_req_rdy", 32'(if0.req_rdy), 32'(4'b0010));
    sb_step(4'b0010, 32'h44335A11);
    drive(0, 4'b0000, DSTD, 1);
    chk("drain_req_rdy", 32'(if0.req_rdy), 32'(0));
    sb_step(4'b0000, DSTD);
    drive(0, 4'b0000, DSTD, 1);
    chk("drain_ovalid", 32'(if0.ovalid), 32'(0));
    chk("sb_empty", 32'(sbq.size()), 32'(0));

    // Burst of 1: pure per-beat round-robin
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if1.req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      #1;
      $display("rr1 cycle %0d req_rdy=%b ovalid=%0b dout=%h", c, if1.req_rdy, if1.ovalid, if1.dout);
      chk($sformatf("rr1_c%0d_req_rdy", c), 32'(if1.req_rdy), (c < 5) ? 32'(1 << (c % 4)) : 32'(0));
      chk($sformatf("rr1_c%0d_grant", c),   32'(if1.grant),   32'(0));
      chk($sformatf("rr1_c%0d_busy", c),    32'(if1.busy),    32'(0));
      if (c >= 1) begin
        chk($sformatf("rr1_c%0d_ovalid", c), 32'(if1.ovalid), 32'(1));
        chk($sformatf("rr1_c%0d_dout", c),   32'(if1.dout),   32'(8'h11 * (((c - 1) % 4) + 1)));
`ifdef PIPE_ARB_SRCID_EN
        chk($sformatf("rr1_c%0d_osrc", c),   32'(if1.osrc),   32'((c - 1) % 4));
`endif
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_rr_arbiter.md
# pipe_rr_arbiter

Round-robin arbiter that shares one registered 8-bit pipeline stage among N upstream requesters using valid/ready handshakes. Each requester may hold the stage for a bounded burst of consecutive beats before it must yield. The block sits between several producers and a single downstream consumer that can stall via `rdy`. It owns the output register, so it is the stage rather than a sideband to it.

## Interface
- `N`, 4: number of requesters, 2..8.
- `W`, 8: data width.
- `MAX_BURST`, 4: maximum consecutive beats per grant, 1..15.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in N: per-requester valid.
- `req_data` in N*W: requester i data in bits [i*W +: W].
- `req_rdy` out N: per-requester ready (combinational).
- `rdy` in 1: downstream ready.
- `ovalid` out 1: output register valid.
- `dout` out W: output register data.
- `grant` out N: one-hot current owner; 0 when idle.
- `busy` out 1: 1 while a burst owner is locked (state OWN).

## Operation
- State: `st` (IDLE/OWN), `owner` (index), `ptr` (RR start index), `cnt` (beats in current burst).
- `load_en = ~ovalid | rdy`. When `rdy` is 0 and `ovalid` is 1, all state and outputs freeze and `req_rdy` is all zero.
- Selection, evaluated only when `load_en` is 1:
  - If `st==OWN` and `req_valid[owner]` is 1, select `owner`.
  - Otherwise select the first i with `req_valid[i]`, scanning from `ptr` upward modulo N.
- `req_rdy[s] = load_en & ~rst` for the selected s; all other bits are 0. A beat is accepted when `req_valid[s] & req_rdy[s]`.
- On an accepted beat from s:
  - `dout <= req_data[s]`, `ovalid <= 1`, `ptr <= (s+1) mod N`.
  - New `cnt` = `cnt+1` if `st==OWN` and `s==owner`; otherwise 1. Set `owner <= s`.
  - If the new `cnt == MAX_BURST`, go to IDLE. Otherwise go to OWN.
- When `load_en` is 1 and nothing is accepted: `ovalid <= 0` and `st <= IDLE`. `ptr` keeps its value, so the yielding owner has the lowest priority.
- If the owner drops valid at a load opportunity, another valid requester is granted in the same cycle with no bubble.
- `grant = (st==OWN) ? onehot(owner) : 0`. `busy = (st==OWN)`.
- With `MAX_BURST==1` the block never enters OWN and behaves as pure per-beat round-robin.

## Timing
- Reset values: `ovalid`=0, `dout`=0, `grant`=0, `busy`=0, `req_rdy`=0, `st`=IDLE, `ptr`=0, `cnt`=0, `owner`=0.
- Latency: a beat accepted in cycle t appears on `dout`/`ovalid` in cycle t+1.
- Throughput: one beat per cycle while `rdy` is held 1.
- Downstream transfer occurs when `ovalid & rdy`. `dout` is stable while `ovalid & ~rdy`.
- Simultaneous downstream transfer and upstream accept in the same cycle is allowed (full throughput).
- Upstream valid changes during a stall have no effect until `load_en` returns to 1.
- `rst` mid-burst or mid-stall: the next cycle shows all reset values, and any held beat is dropped.

## Configuration
- `PIPE_ARB_SRCID_EN`:
  - Defined: adds output `osrc` of width `$clog2(N)`. It is registered with `dout`, holds the source index of the beat in the output register, and resets to 0.
  - Undefined: the `osrc` port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, N=4, all `req_valid`=1, `rdy`=1 -> `ovalid`=0 during reset. After release the output source order is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…, with `ovalid` continuously 1.
- Only requester 2 valid, `rdy`=1 -> `req_rdy`=4'b0100 every cycle. `grant` is 4'b0100 for 3 cycles, then `busy` drops for 1 cycle at cnt=4 while beats continue every cycle.
- Requester 1 owns with cnt=2, then drops valid while requesters 0 and 3 are valid -> requester 3 is granted in the same cycle and its data appears next cycle.
- Output holds 0xA5 and `rdy`=0 for 5 cycles while `req_valid`=4'b1111 -> `dout`=0xA5 stable, `req_rdy`=0. The first `rdy`=1 cycle transfers 0xA5 and accepts the next beat.
- `rst` asserted mid-burst with `ovalid`=1 -> next cycle `ovalid`=0, `grant`=0. After release, arbitration restarts from requester 0.
- With `PIPE_ARB_SRCID_EN` defined and MAX_BURST=1, all four valid -> `osrc` sequence is 0,1,2,3,0.
